// File: rtl/sha256_stream_core.sv
// Streaming SHA-256/SHA-224 core: takes pre-padded 512-bit blocks as 32- or 64-bit
// big-endian beats, runs one compression round per cycle, emits the digest word by word.
module sha256_stream_core #(
    parameter int IN_W        = 32,
    parameter int SUPPORT_224 = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_mode,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [IN_W-1:0] i_data,
    input  logic            i_last,
    output logic            o_busy,
    output logic            o_digest_valid,
    input  logic            i_digest_ready,
    output logic [31:0]     o_digest_word,
    output logic [2:0]      o_digest_idx
);
    localparam int WPB   = IN_W / 32;
    localparam int BEATS = 16 / WPB;

    localparam logic [0:7][31:0] IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [0:7][31:0] IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, UPDATE, OUT} state_t;

    state_t           state;
    logic [3:0]       beat_cnt;
    logic [5:0]       rnd;
    logic             last_q;
    logic             mode224;
    logic [0:7][31:0] hv;
    logic [0:7][31:0] h_new;
    logic [31:0]      w [16];
    logic [31:0]      a, b, c, d, e, f, g, h;
    logic [31:0]      t1, t2, w_next;
    logic             final_beat;
    logic             start_224;
    logic [2:0]       last_idx;

    assign final_beat     = (state == LOAD) && i_valid && (beat_cnt == 4'(BEATS - 1));
    assign start_224      = (SUPPORT_224 != 0) && i_mode;
    assign last_idx       = mode224 ? 3'd6 : 3'd7;
    assign o_ready        = (state == LOAD);
    assign o_busy         = (state != IDLE);
    assign o_digest_valid = (state == OUT);

    // Window w[0..15] holds W[t..t+15]; w_next is W[t+16], computed one round ahead.
    always_comb begin
        t1     = h + big_s1(e) + ((e & f) ^ (~e & g)) + K[rnd] + w[0];
        t2     = big_s0(a) + ((a & b) ^ (a & c) ^ (b & c));
        w_next = small_s1(w[14]) + w[9] + small_s0(w[1]) + w[0];
        h_new  = {hv[0] + a, hv[1] + b, hv[2] + c, hv[3] + d,
                  hv[4] + e, hv[5] + f, hv[6] + g, hv[7] + h};
    end

    always_ff @(posedge i_clk) begin
        if (state == LOAD && i_valid) begin
            for (int i = 0; i < 16 - WPB; i++) w[i] <= w[i + WPB];
            for (int j = 0; j < WPB; j++) w[16 - WPB + j] <= i_data[IN_W - 1 - 32 * j -: 32];
        end else if (state == ROUND) begin
            for (int i = 0; i < 15; i++) w[i] <= w[i + 1];
            w[15] <= w_next;
        end

        if (final_beat) begin
            {a, b, c, d, e, f, g, h} <= hv;
        end else if (state == ROUND) begin
            h <= g;
            g <= f;
            f <= e;
            e <= d + t1;
            d <= c;
            c <= b;
            b <= a;
            a <= t1 + t2;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            rnd           <= '0;
            last_q        <= 1'b0;
            mode224       <= 1'b0;
            hv            <= IV256;
            o_digest_word <= '0;
            o_digest_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        hv       <= start_224 ? IV224 : IV256;
                        mode224  <= start_224;
                        beat_cnt <= '0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (i_valid) begin
                        if (beat_cnt == 4'(BEATS - 1)) begin
                            last_q <= i_last;
                            rnd    <= '0;
                            state  <= ROUND;
                        end else begin
                            beat_cnt <= beat_cnt + 4'd1;
                        end
                    end
                end
                ROUND: begin
                    rnd <= rnd + 6'd1;
                    if (rnd == 6'd63) state <= UPDATE;
                end
                UPDATE: begin
                    hv       <= h_new;
                    beat_cnt <= '0;
                    if (last_q) begin
                        o_digest_idx  <= '0;
                        o_digest_word <= h_new[0];
                        state         <= OUT;
                    end else begin
                        state <= LOAD;
                    end
                end
                OUT: begin
                    if (i_digest_ready) begin
                        if (o_digest_idx == last_idx) begin
                            o_digest_idx  <= '0;
                            o_digest_word <= '0;
                            state         <= IDLE;
                        end else begin
                            o_digest_idx  <= o_digest_idx + 3'd1;
                            o_digest_word <= hv[o_digest_idx + 3'd1];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
